// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS32 IF/MEM memory arbiter: FSM states, owner tags, default widths.
package mips_mem_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus between the datapath/memory side (master) and the memory arbiter (slave).
interface mips_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests, with a starvation counter
// that forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   arb_en,
  input  logic   gnt_fire,
  output logic   win_valid,
  output owner_t win_owner
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  always_comb begin
    starved   = if_req && (starve_cnt == CW'(STARVE_MAX));
    win_valid = arb_en && (if_req || d_req);
    win_owner = (d_req && !starved) ? OWN_D : OWN_IF;
  end

  // Only arbitration cycles touch the counter; an idle fetch port wipes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (gnt_fire && win_owner == OWN_IF) begin
        starve_cnt <= '0;
      end else if (gnt_fire && starve_cnt < CW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for MIPS32 fetch and load/store ports, one access in flight.
// Optional statistics counters are enabled with `define MIPS_MEM_ARB_STATS_EN.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mips_mem_arbiter_if.slave bus
`ifdef MIPS_MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_wait_cycles
`endif
);

  localparam int LW = $clog2(MEM_LAT + 1);

  state_t        state, state_n;
  owner_t        owner, owner_n;
  logic          we_q, we_n;
  logic [LW-1:0] lat_cnt, lat_n;

  logic          arb_en, win_valid;
  owner_t        win_owner;

  logic          if_gnt_n, d_gnt_n, if_rvalid_n, d_rvalid_n;
  logic          mem_en_n, mem_we_n, busy_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;

  assign arb_en = (state == ST_IDLE) || (state == ST_RESP);

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk       (clk),
    .rst       (rst),
    .if_req    (bus.if_req),
    .d_req     (bus.d_req),
    .arb_en    (arb_en),
    .gnt_fire  (win_valid),
    .win_valid (win_valid),
    .win_owner (win_owner)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    we_n        = we_q;
    lat_n       = lat_cnt;
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_rvalid_n = 1'b0;
    d_rvalid_n  = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;
    if_rdata_n  = bus.if_rdata;
    d_rdata_n   = bus.d_rdata;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (win_valid) begin
          state_n  = ST_ISSUE;
          owner_n  = win_owner;
          mem_en_n = 1'b1;
          if (win_owner == OWN_D) begin
            d_gnt_n     = 1'b1;
            we_n        = bus.d_we;
            mem_we_n    = bus.d_we;
            mem_addr_n  = bus.d_addr;
            mem_wdata_n = bus.d_wdata;
          end else begin
            if_gnt_n   = 1'b1;
            we_n       = 1'b0;
            mem_addr_n = bus.if_addr;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
        lat_n   = LW'(1);
      end
      ST_WAIT: begin
        if (lat_cnt == LW'(MEM_LAT)) begin
          state_n = ST_RESP;
          if (owner == OWN_IF) begin
            if_rvalid_n = 1'b1;
            if_rdata_n  = bus.mem_rdata;
          end else begin
            d_rvalid_n = 1'b1;
            if (!we_q) d_rdata_n = bus.mem_rdata;
          end
        end else begin
          lat_n = lat_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= OWN_IF;
      we_q          <= 1'b0;
      lat_cnt       <= '0;
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      we_q          <= we_n;
      lat_cnt       <= lat_n;
      bus.if_gnt    <= if_gnt_n;
      bus.d_gnt     <= d_gnt_n;
      bus.if_rvalid <= if_rvalid_n;
      bus.d_rvalid  <= d_rvalid_n;
      bus.if_rdata  <= if_rdata_n;
      bus.d_rdata   <= d_rdata_n;
      bus.mem_en    <= mem_en_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
      bus.busy      <= busy_n;
    end
  end

`ifdef MIPS_MEM_ARB_STATS_EN
  // A waiting cycle is any cycle with a request up and no grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_grants   <= '0;
      stat_d_grants    <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (bus.if_gnt) stat_if_grants <= stat_if_grants + 1'b1;
      if (bus.d_gnt)  stat_d_grants  <= stat_d_grants + 1'b1;
      if ((bus.if_req || bus.d_req) && !bus.if_gnt && !bus.d_gnt)
        stat_wait_cycles <= stat_wait_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mips_mem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h40) ? 32'hDEADBEEF : {16'hC0DE, addr[15:0]};
  endfunction

  // Memory models: read data is only meaningful exactly MEM_LAT cycles after mem_en.
  logic        v1 = 1'b0;
  logic [31:0] a1 = '0;
  always @(posedge clk) begin
    v1 <= bus1.mem_en && !bus1.mem_we;
    a1 <= bus1.mem_addr;
  end
  assign bus1.mem_rdata = v1 ? mem_word(a1) : 32'hBAD0BAD0;

  logic [2:0]  v3 = '0;
  logic [31:0] a3 [3];
  always @(posedge clk) begin
    v3    <= {v3[1:0], bus3.mem_en && !bus3.mem_we};
    a3[0] <= bus3.mem_addr;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign bus3.mem_rdata = v3[2] ? mem_word(a3[2]) : 32'hBAD0BAD0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                               input logic d_req, input logic d_we,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata);
    bus1.if_req  = if_req;
    bus1.if_addr = if_addr;
    bus1.d_req   = d_req;
    bus1.d_we    = d_we;
    bus1.d_addr  = d_addr;
    bus1.d_wdata = d_wdata;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (bus1.busy && n < 20) begin
      tick();
      n++;
    end
    tick();
    checkOutput(tag, bus1.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fetch_data [3];
    fetch_data = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008};

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0;
    bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;
    tick();
    tick();
    checkOutput("rst_busy", bus1.busy, 1'b0);
    checkOutput("rst_mem_en", bus1.mem_en, 1'b0);
    checkOutput("rst_gnt", {bus1.if_gnt, bus1.d_gnt}, 2'b00);
    checkOutput("rst_mem_addr", bus1.mem_addr, 32'h0);
    checkOutput("rst_d_rdata", bus1.d_rdata, 32'h0);
    rst = 1'b0;

    // Single load from 0x40
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
    tick();
    checkOutput("ld_d_gnt", bus1.d_gnt, 1'b1);
    checkOutput("ld_mem_en", bus1.mem_en, 1'b1);
    checkOutput("ld_mem_addr", bus1.mem_addr, 32'h40);
    checkOutput("ld_mem_we", bus1.mem_we, 1'b0);
    checkOutput("ld_if_gnt", bus1.if_gnt, 1'b0);
    checkOutput("ld_busy", bus1.busy, 1'b1);
    bus1.d_req = 1'b0;
    tick();
    checkOutput("ld_wait_gnt", bus1.d_gnt, 1'b0);
    checkOutput("ld_wait_mem_en", bus1.mem_en, 1'b0);
    checkOutput("ld_wait_rvalid", bus1.d_rvalid, 1'b0);
    tick();
    checkOutput("ld_rvalid", bus1.d_rvalid, 1'b1);
    checkOutput("ld_rdata", bus1.d_rdata, 32'hDEADBEEF);
    checkOutput("ld_if_rvalid", bus1.if_rvalid, 1'b0);
    tick();
    checkOutput("ld_rvalid_off", bus1.d_rvalid, 1'b0);
    checkOutput("ld_idle", bus1.busy, 1'b0);

    // Store to 0x80
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h80, 32'h1234);
    tick();
    checkOutput("st_d_gnt", bus1.d_gnt, 1'b1);
    checkOutput("st_mem_we", bus1.mem_we, 1'b1);
    checkOutput("st_mem_wdata", bus1.mem_wdata, 32'h1234);
    checkOutput("st_mem_addr", bus1.mem_addr, 32'h80);
    bus1.d_req = 1'b0;
    tick();
    checkOutput("st_wait_rvalid", bus1.d_rvalid, 1'b0);
    tick();
    checkOutput("st_rvalid", bus1.d_rvalid, 1'b1);
    checkOutput("st_rdata_hold", bus1.d_rdata, 32'hDEADBEEF);
    tick();
    checkOutput("st_idle", bus1.busy, 1'b0);

    // Back-to-back fetch stream 0x0, 0x4, 0x8
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      checkOutput("fetch_busy", bus1.busy, 1'b1);
      checkOutput("fetch_gnt", bus1.if_gnt, (c % 3 == 1));
      checkOutput("fetch_rvalid", bus1.if_rvalid, (c % 3 == 0));
      if (c % 3 == 0) checkOutput("fetch_rdata", bus1.if_rdata, fetch_data[c/3 - 1]);
      if (c == 1) bus1.if_addr = 32'h4;
      if (c == 4) bus1.if_addr = 32'h8;
      if (c == 7) bus1.if_req = 1'b0;
    end
    tick();
    checkOutput("fetch_idle", bus1.busy, 1'b0);

    // Contention: grants D,D,D,D,IF then D again, every 3 cycles
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, '0);
    for (int c = 1; c <= 16; c++) begin
      logic [1:0] exp_gnt;
      tick();
      if ((c - 1) % 3 == 0) exp_gnt = (((c - 1) / 3) == 4) ? 2'b10 : 2'b01;
      else exp_gnt = 2'b00;
      checkOutput("contend_gnt", {bus1.if_gnt, bus1.d_gnt}, exp_gnt);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    drain("contend_drain");

    // Reset during WAIT drops the load
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
    tick();
    checkOutput("rstw_gnt", bus1.d_gnt, 1'b1);
    bus1.d_req = 1'b0;
    tick();
    checkOutput("rstw_in_wait", bus1.busy, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("rstw_rvalid", bus1.d_rvalid, 1'b0);
    checkOutput("rstw_busy", bus1.busy, 1'b0);
    checkOutput("rstw_mem_en", bus1.mem_en, 1'b0);
    checkOutput("rstw_d_rdata", bus1.d_rdata, 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("rstw_no_rvalid", bus1.d_rvalid, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h44, '0);
    tick();
    checkOutput("rstw_new_gnt", bus1.d_gnt, 1'b1);
    bus1.d_req = 1'b0;
    tick();
    tick();
    checkOutput("rstw_new_rvalid", bus1.d_rvalid, 1'b1);
    checkOutput("rstw_new_rdata", bus1.d_rdata, 32'hC0DE0044);

    // MEM_LAT=3 fetch on the second instance
    bus3.if_req  = 1'b1;
    bus3.if_addr = 32'h20;
    tick();
    checkOutput("lat3_gnt", bus3.if_gnt, 1'b1);
    checkOutput("lat3_mem_en", bus3.mem_en, 1'b1);
    bus3.if_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checkOutput("lat3_wait_rvalid", bus3.if_rvalid, 1'b0);
      checkOutput("lat3_wait_busy", bus3.busy, 1'b1);
    end
    tick();
    checkOutput("lat3_rvalid", bus3.if_rvalid, 1'b1);
    checkOutput("lat3_rdata", bus3.if_rdata, 32'hC0DE0020);
    tick();
    checkOutput("lat3_idle", bus3.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the MIPS32 datapath's instruction-fetch (IF) port and data (MEM-stage load/store) port.
- One transaction in flight at a time.
- Data port has priority; a starvation counter guarantees forward progress for fetch.
- Sits between the datapath stage logic and the unified instruction/data memory.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (>=1)
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced to win (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; hold stable with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  1-cycle pulse: fetch issued to memory
- if_rvalid  out  1  1-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched instruction
- d_req  in  1  data request; hold stable with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  1-cycle pulse: data access issued
- d_rvalid  out  1  1-cycle pulse: load data valid, or store complete
- d_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, starve_cnt = 0, owner = IF.
- All outputs are registered.
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: exactly 1 cycle. mem_en=1, mem_we/mem_addr/mem_wdata from the winner, winner's gnt=1.
  - WAIT: MEM_LAT cycles. mem_en=0, lat_cnt counts 1..MEM_LAT. On the final cycle, mem_rdata is captured into the winner's rdata register.
  - RESP: exactly 1 cycle. Winner's rvalid=1. Arbitrates like IDLE.
- Transitions:
  - IDLE or RESP, any request -> ISSUE.
  - IDLE or RESP, no request -> IDLE.
  - ISSUE -> WAIT.
  - WAIT, lat_cnt==MEM_LAT -> RESP.
- Latency: request seen in cycle 0 (IDLE) -> gnt + mem_en in cycle 1 -> rvalid in cycle 2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- Arbitration (IDLE/RESP only):
  - If d_req && !(if_req && starve_cnt==STARVE_MAX), data wins; otherwise fetch wins if if_req.
  - Requests are ignored during ISSUE/WAIT, so a requester holding req through its own gnt cycle is not re-granted.
- Starvation counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or in any arbitration cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Stores: d_rvalid pulses in RESP as the completion ack; d_rdata holds its previous value.
- if_rdata/d_rdata hold their last value until the next capture for that port.
- Simultaneous requests with starve_cnt<STARVE_MAX: data wins; fetch stays pending and is counted.
- Reset mid-transaction: the transaction is dropped, no rvalid is issued, and the FSM returns to IDLE next cycle.
- A request deasserted before gnt (protocol violation): the arbiter only samples in IDLE/RESP. No recovery is required beyond completing whatever was issued.

Optional Feature:
- Macro MIPS_MEM_ARB_STATS_EN.
- When defined, adds 32-bit wrap-around output counters, all reset to 0:
  - stat_if_grants (fetch grants)
  - stat_d_grants (data grants)
  - stat_wait_cycles (cycles where if_req or d_req is high and no gnt is asserted)
- When undefined, these ports and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_mem_pkg: state enum (ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP), owner enum (OWN_IF, OWN_D), default AW/DW constants.
- Sub-module mem_arb_pick: starvation counter plus winner selection.
  - Inputs: if_req, d_req, arb_en, gnt_fire.
  - Outputs: win_valid, win_owner.
- The top level holds the FSM, latency counter and datapath registers.

Test Plan:
- Single load, MEM_LAT=1: d_req, d_we=0, d_addr=0x40, memory holds 0xDEADBEEF at cycle 0 -> d_gnt and mem_en at cycle 1, mem_addr=0x40, d_rvalid at cycle 3, d_rdata=0xDEADBEEF, if_* idle.
- Store: d_we=1, d_addr=0x80, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 in the ISSUE cycle; d_rvalid pulse 2 cycles later; d_rdata unchanged.
- Contention: if_req and d_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF repeating; grants spaced 3 cycles apart (MEM_LAT=1).
- Fetch-only stream, addresses 0x0, 0x4, 0x8 -> if_rvalid with matching data every 3 cycles; busy stays 1 throughout.
- MEM_LAT=3 override: fetch -> if_rvalid arrives 5 cycles after request sampled; data captured from mem_rdata in the 3rd WAIT cycle.
- rst asserted during WAIT -> next cycle all outputs 0, no rvalid for the dropped request; a new d_req afterwards is served normally.
